// File: rtl/gerenciador_de_ataque_n.sv
// Attack manager for the naval-battle game: validates shots against the hidden
// ship map, accumulates hits on the LED matrix, tracks lives and declares the
// end of the game (victory or defeat).
module gerenciador_de_ataque_n #(
  parameter int COLS  = 5,
  parameter int ROWS  = 7,
  parameter int VIDAS = 3,
  parameter int VW    = $clog2(VIDAS + 1)
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 enable,
  input  logic                 confirmar,
  input  logic [2:0]           coordColuna,
  input  logic [2:0]           coordLinha,
  input  logic [COLS*ROWS-1:0] mapa,
  output logic [COLS*ROWS-1:0] matriz,
  output logic                 LED_R,
  output logic                 LED_G,
  output logic                 LED_B,
  output logic [VW-1:0]        vida,
  output logic                 vitoria,
  output logic                 derrota,
  output logic                 ocupado
);

  localparam int N  = COLS * ROWS;
  localparam int AW = $clog2(N + 1);

  typedef enum logic [1:0] {
    OCIOSO   = 2'd0,
    AVALIA   = 2'd1,
    VERIFICA = 2'd2,
    FIM      = 2'd3
  } estado_t;

  // Number of ship cells in the map; victory when the hit counter reaches it.
  function automatic logic [AW-1:0] popcount(input logic [N-1:0] v);
    logic [AW-1:0] c;
    c = '0;
    for (int i = 0; i < N; i++) begin
      c = c + AW'(v[i]);
    end
    return c;
  endfunction

  // One-hot mask of a cell; all-zero when the coordinate falls outside the matrix.
  function automatic logic [N-1:0] cell_mask(input logic [2:0] c, input logic [2:0] r);
    logic [N-1:0] m;
    if ((int'(c) < COLS) && (int'(r) < ROWS)) begin
      m = N'(1'b1) << (int'(c) * ROWS + int'(r));
    end else begin
      m = '0;
    end
    return m;
  endfunction

  estado_t       state_q, state_d;
  logic [N-1:0]  matriz_q, matriz_d;
  logic [N-1:0]  tiros_q, tiros_d;
  logic [AW-1:0] acertos_q, acertos_d;
  logic [2:0]    col_q, col_d;
  logic [2:0]    lin_q, lin_d;
  logic          conf_ant_q, conf_ant_d;
  logic [VW-1:0] vida_q, vida_d;
  logic          led_r_q, led_r_d;
  logic          led_g_q, led_g_d;
  logic          led_b_q, led_b_d;
  logic          vitoria_q, vitoria_d;
  logic          derrota_q, derrota_d;
  logic          ocupado_q, ocupado_d;

  logic [N-1:0]  mask_s;
  logic          evento_s;

  assign mask_s   = cell_mask(col_q, lin_q);
  assign evento_s = confirmar & ~conf_ant_q;

  // Next-state and next-output logic of the shot FSM; everything holds by default.
  always_comb begin
    state_d    = state_q;
    matriz_d   = matriz_q;
    tiros_d    = tiros_q;
    acertos_d  = acertos_q;
    col_d      = col_q;
    lin_d      = lin_q;
    conf_ant_d = confirmar;
    vida_d     = vida_q;
    led_r_d    = led_r_q;
    led_g_d    = led_g_q;
    led_b_d    = led_b_q;
    vitoria_d  = vitoria_q;
    derrota_d  = derrota_q;

    case (state_q)
      OCIOSO: begin
        if (evento_s) begin
          col_d   = coordColuna;
          lin_d   = coordLinha;
          state_d = AVALIA;
        end else begin
          state_d = OCIOSO;
        end
      end
      AVALIA: begin
        // An out-of-range cell yields an empty mask, so it lands in the invalid case.
        if ((mask_s == '0) || ((mask_s & tiros_q) != '0)) begin
          led_r_d = 1'b0;
          led_g_d = 1'b0;
          led_b_d = 1'b1;
        end else if ((mask_s & mapa) != '0) begin
          tiros_d   = tiros_q | mask_s;
          matriz_d  = matriz_q | mask_s;
          acertos_d = acertos_q + AW'(1'b1);
          led_r_d   = 1'b0;
          led_g_d   = 1'b1;
          led_b_d   = 1'b0;
        end else begin
          tiros_d = tiros_q | mask_s;
          vida_d  = vida_q - VW'(1'b1);
          led_r_d = 1'b1;
          led_g_d = 1'b0;
          led_b_d = 1'b0;
        end
        state_d = VERIFICA;
      end
      VERIFICA: begin
        if (vida_q == '0) begin
          derrota_d = 1'b1;
          state_d   = FIM;
        end else if ((mapa != '0) && (acertos_q == popcount(mapa))) begin
          vitoria_d = 1'b1;
          state_d   = FIM;
        end else begin
          state_d = OCIOSO;
        end
      end
      FIM: begin
        state_d = FIM;
      end
      default: begin
        state_d = OCIOSO;
      end
    endcase

    ocupado_d = (state_d == AVALIA) || (state_d == VERIFICA);
  end

  // State and output registers; reset or a disabled game clears everything at the edge.
  always_ff @(posedge clock) begin
    if (reset || !enable) begin
      state_q    <= OCIOSO;
      matriz_q   <= '0;
      tiros_q    <= '0;
      acertos_q  <= '0;
      col_q      <= 3'd0;
      lin_q      <= 3'd0;
      conf_ant_q <= 1'b0;
      vida_q     <= VW'(VIDAS);
      led_r_q    <= 1'b0;
      led_g_q    <= 1'b0;
      led_b_q    <= 1'b0;
      vitoria_q  <= 1'b0;
      derrota_q  <= 1'b0;
      ocupado_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      matriz_q   <= matriz_d;
      tiros_q    <= tiros_d;
      acertos_q  <= acertos_d;
      col_q      <= col_d;
      lin_q      <= lin_d;
      conf_ant_q <= conf_ant_d;
      vida_q     <= vida_d;
      led_r_q    <= led_r_d;
      led_g_q    <= led_g_d;
      led_b_q    <= led_b_d;
      vitoria_q  <= vitoria_d;
      derrota_q  <= derrota_d;
      ocupado_q  <= ocupado_d;
    end
  end

  assign matriz  = matriz_q;
  assign LED_R   = led_r_q;
  assign LED_G   = led_g_q;
  assign LED_B   = led_b_q;
  assign vida    = vida_q;
  assign vitoria = vitoria_q;
  assign derrota = derrota_q;
  assign ocupado = ocupado_q;

endmodule

// File: tb/tb_gerenciador_de_ataque_n.sv
// Self-checking bench for gerenciador_de_ataque_n: directed game scenarios plus
// random games, all checked against a cell-level game model kept here.
module tb_gerenciador_de_ataque_n;

  localparam int COLS = 5;
  localparam int ROWS = 7;
  localparam int N    = COLS * ROWS;
  localparam int VW   = 2;

  typedef logic [N+7:0] vec_t;

  logic          clock = 1'b0;
  logic          reset, enable, confirmar;
  logic [2:0]    coordColuna, coordLinha;
  logic [N-1:0]  mapa, matriz;
  logic          LED_R, LED_G, LED_B;
  logic [VW-1:0] vida;
  logic          vitoria, derrota, ocupado;

  int vectors = 0;
  int miscompares = 0;

  // Game model: cells hit, cells shot, lives, LEDs, flags, game-over.
  logic [N-1:0] e_matriz, e_tiros;
  int           e_vida;
  logic         e_r, e_g, e_b, e_vit, e_der, e_fim;
  vec_t         x_pre, x_mid, s_n, s_n1;

  localparam logic [N-1:0] MAPA_PLANO = {7'b1110000, 21'd0, 7'b1110001};

  gerenciador_de_ataque_n #(.COLS(COLS), .ROWS(ROWS), .VIDAS(3), .VW(VW)) dut (
    .clock(clock), .reset(reset), .enable(enable), .confirmar(confirmar),
    .coordColuna(coordColuna), .coordLinha(coordLinha), .mapa(mapa),
    .matriz(matriz), .LED_R(LED_R), .LED_G(LED_G), .LED_B(LED_B),
    .vida(vida), .vitoria(vitoria), .derrota(derrota), .ocupado(ocupado)
  );

  always #5 clock = ~clock;

  function automatic vec_t obs_vec();
    return {matriz, LED_R, LED_G, LED_B, vida, vitoria, derrota, ocupado};
  endfunction

  function automatic vec_t exp_vec(input logic busy);
    return {e_matriz, e_r, e_g, e_b, VW'(e_vida), e_vit, e_der, busy};
  endfunction

  task automatic model_clear();
    e_matriz = '0; e_tiros = '0; e_vida = 3;
    e_r = 1'b0; e_g = 1'b0; e_b = 1'b0;
    e_vit = 1'b0; e_der = 1'b0; e_fim = 1'b0;
  endtask

  // Apply one shot to the model, recording expected states at n and n+1.
  task automatic model_shot(input int c, input int r);
    x_pre = exp_vec(!e_fim);
    if (e_fim) begin
      x_mid = x_pre;
    end else begin
      if (c >= COLS || r >= ROWS) begin
        e_r = 1'b0; e_g = 1'b0; e_b = 1'b1;
      end else if (e_tiros[c*ROWS+r]) begin
        e_r = 1'b0; e_g = 1'b0; e_b = 1'b1;
      end else if (mapa[c*ROWS+r]) begin
        e_tiros[c*ROWS+r] = 1'b1; e_matriz[c*ROWS+r] = 1'b1;
        e_r = 1'b0; e_g = 1'b1; e_b = 1'b0;
      end else begin
        e_tiros[c*ROWS+r] = 1'b1; e_vida = e_vida - 1;
        e_r = 1'b1; e_g = 1'b0; e_b = 1'b0;
      end
      x_mid = exp_vec(1'b1);
      if (e_vida == 0) begin
        e_der = 1'b1; e_fim = 1'b1;
      end else if (mapa != '0 && e_matriz == mapa) begin
        e_vit = 1'b1; e_fim = 1'b1;
      end
    end
  endtask

  // One-cycle confirm pulse; snapshots after edges n and n+1, returns after n+2.
  task automatic shoot(input int c, input int r);
    @(negedge clock);
    coordColuna = 3'(c); coordLinha = 3'(r); confirmar = 1'b1;
    @(negedge clock);
    s_n = obs_vec();
    confirmar = 1'b0; coordColuna = 3'($urandom); coordLinha = 3'($urandom);
    @(negedge clock);
    s_n1 = obs_vec();
    @(negedge clock);
    model_shot(c, r);
  endtask

  task automatic do_reset();
    @(negedge clock); reset = 1'b1;
    @(negedge clock); reset = 1'b0;
    model_clear();
  endtask

  task automatic test_reset();
    mapa = MAPA_PLANO;
    do_reset();
    vectors++;
    if (obs_vec() !== exp_vec(1'b0)) begin
      miscompares++;
      $display("FAIL reset_state: got %h expected %h", obs_vec(), exp_vec(1'b0));
    end
  endtask

  task automatic test_hit();
    shoot(0, 0);
    vectors++;
    if (s_n !== x_pre) begin miscompares++; $display("FAIL hit_edge_n: got %h expected %h", s_n, x_pre); end
    vectors++;
    if (s_n1 !== x_mid) begin miscompares++; $display("FAIL hit_edge_n1: got %h expected %h", s_n1, x_mid); end
    vectors++;
    if (obs_vec() !== exp_vec(1'b0)) begin
      miscompares++; $display("FAIL hit_edge_n2: got %h expected %h", obs_vec(), exp_vec(1'b0));
    end
  endtask

  task automatic test_invalid();
    int cs[3] = '{0, 5, 0};
    int rs[3] = '{0, 0, 7};
    for (int i = 0; i < 3; i++) begin
      shoot(cs[i], rs[i]);
      vectors++;
      if (obs_vec() !== exp_vec(1'b0) || LED_B !== 1'b1) begin
        miscompares++; $display("FAIL invalid_%0d: got %h expected %h", i, obs_vec(), exp_vec(1'b0));
      end
    end
  endtask

  task automatic test_miss_defeat();
    int base;
    base = int'($urandom_range(0, 4));
    for (int i = 0; i < 4; i++) begin
      if (i < 3) shoot(2, base + i);
      else shoot(1, 1);
      vectors++;
      if (s_n !== x_pre) begin miscompares++; $display("FAIL defeat_n_%0d: got %h expected %h", i, s_n, x_pre); end
      vectors++;
      if (s_n1 !== x_mid) begin miscompares++; $display("FAIL defeat_n1_%0d: got %h expected %h", i, s_n1, x_mid); end
      vectors++;
      if (obs_vec() !== exp_vec(1'b0)) begin
        miscompares++; $display("FAIL defeat_n2_%0d: got %h expected %h", i, obs_vec(), exp_vec(1'b0));
      end
    end
    vectors++;
    if (derrota !== 1'b1 || vida !== 2'd0) begin
      miscompares++; $display("FAIL defeat_flag: got derrota=%b vida=%0d expected 1 0", derrota, vida);
    end
  endtask

  task automatic test_enable_clear();
    @(negedge clock); enable = 1'b0;
    @(negedge clock); enable = 1'b1;
    model_clear();
    vectors++;
    if (obs_vec() !== exp_vec(1'b0)) begin
      miscompares++; $display("FAIL enable_clear: got %h expected %h", obs_vec(), exp_vec(1'b0));
    end
    shoot(4, 4);
    vectors++;
    if (obs_vec() !== exp_vec(1'b0)) begin
      miscompares++; $display("FAIL after_enable_shot: got %h expected %h", obs_vec(), exp_vec(1'b0));
    end
  endtask

  task automatic test_victory();
    int cells[7] = '{0, 4, 5, 6, 32, 33, 34};
    int plan[$];
    int m1, m2, j, t;
    do_reset();
    for (int i = 6; i > 0; i--) begin
      j = int'($urandom_range(0, i));
      t = cells[i]; cells[i] = cells[j]; cells[j] = t;
    end
    m1 = int'($urandom_range(0, 6));
    m2 = int'($urandom_range(0, 6));
    for (int i = 0; i < 7; i++) begin
      if (i == m1) plan.push_back(7);
      if (i == m2) plan.push_back(8);
      plan.push_back(cells[i]);
    end
    foreach (plan[k]) begin
      shoot(plan[k] / ROWS, plan[k] % ROWS);
      vectors++;
      if (s_n1 !== x_mid) begin miscompares++; $display("FAIL victory_n1_%0d: got %h expected %h", k, s_n1, x_mid); end
      vectors++;
      if (obs_vec() !== exp_vec(1'b0)) begin
        miscompares++; $display("FAIL victory_n2_%0d: got %h expected %h", k, obs_vec(), exp_vec(1'b0));
      end
    end
    vectors++;
    if (vitoria !== 1'b1 || matriz !== mapa || derrota !== 1'b0) begin
      miscompares++; $display("FAIL victory_final: got vit=%b matriz=%h expected 1 %h", vitoria, matriz, mapa);
    end
  endtask

  task automatic test_hold_and_drop();
    do_reset();
    @(negedge clock);
    coordColuna = 3'd3; coordLinha = 3'd3; confirmar = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clock);
      if (i == 3) model_shot(3, 3);
      if (i >= 3) begin
        vectors++;
        if (obs_vec() !== exp_vec(1'b0)) begin
          miscompares++; $display("FAIL hold_%0d: got %h expected %h", i, obs_vec(), exp_vec(1'b0));
        end
      end
    end
    confirmar = 1'b0;
    // Second pulse lands at edge n+2 while ocupado is still set.
    @(negedge clock); coordColuna = 3'd1; coordLinha = 3'd4; confirmar = 1'b1;
    @(negedge clock); confirmar = 1'b0;
    @(negedge clock); coordColuna = 3'd0; coordLinha = 3'd4; confirmar = 1'b1;
    @(negedge clock); confirmar = 1'b0;
    @(negedge clock);
    @(negedge clock);
    model_shot(1, 4);
    vectors++;
    if (obs_vec() !== exp_vec(1'b0)) begin
      miscompares++; $display("FAIL drop_busy: got %h expected %h", obs_vec(), exp_vec(1'b0));
    end
  endtask

  task automatic test_abort();
    shoot(0, 6);
    @(negedge clock); coordColuna = 3'd0; coordLinha = 3'd5; confirmar = 1'b1;
    @(negedge clock); confirmar = 1'b0; reset = 1'b1;
    @(negedge clock); reset = 1'b0;
    model_clear();
    vectors++;
    if (obs_vec() !== exp_vec(1'b0)) begin
      miscompares++; $display("FAIL abort_reset: got %h expected %h", obs_vec(), exp_vec(1'b0));
    end
    @(negedge clock); coordColuna = 3'd4; coordLinha = 3'd0; confirmar = 1'b1;
    @(negedge clock); confirmar = 1'b0;
    @(negedge clock); enable = 1'b0;
    @(negedge clock); enable = 1'b1;
    vectors++;
    if (obs_vec() !== exp_vec(1'b0)) begin
      miscompares++; $display("FAIL abort_enable: got %h expected %h", obs_vec(), exp_vec(1'b0));
    end
    shoot(0, 5);
    vectors++;
    if (obs_vec() !== exp_vec(1'b0)) begin
      miscompares++; $display("FAIL after_abort: got %h expected %h", obs_vec(), exp_vec(1'b0));
    end
  endtask

  task automatic test_random_games();
    logic [63:0] r64;
    int c, r;
    for (int g = 0; g < 5; g++) begin
      r64 = {$urandom, $urandom} & {$urandom, $urandom};
      mapa = (g == 0) ? '0 : r64[N-1:0];
      do_reset();
      for (int s = 0; s < 30 && !e_fim; s++) begin
        c = int'($urandom_range(0, 7));
        r = int'($urandom_range(0, 7));
        if ($urandom_range(0, 3) != 0) begin
          c = c % COLS; r = r % ROWS;
        end
        shoot(c, r);
        vectors++;
        if (s_n1 !== x_mid) begin miscompares++; $display("FAIL rand_n1_g%0d_s%0d: got %h expected %h", g, s, s_n1, x_mid); end
        vectors++;
        if (obs_vec() !== exp_vec(1'b0)) begin
          miscompares++; $display("FAIL rand_n2_g%0d_s%0d: got %h expected %h", g, s, obs_vec(), exp_vec(1'b0));
        end
      end
    end
  endtask

  initial begin
    reset = 1'b1; enable = 1'b1; confirmar = 1'b0;
    coordColuna = 3'd0; coordLinha = 3'd0; mapa = MAPA_PLANO;
    model_clear();
    test_reset();
    test_hit();
    test_invalid();
    test_miss_defeat();
    test_enable_clear();
    test_victory();
    test_hold_and_drop();
    test_abort();
    test_random_games();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
